jt8255_peer: RTL and testbench



---
 rtl/jt8255_peer.sv | 240 ++++++++++++++++++++++++
 tb/tb_jt8255_peer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt8255_peer.sv
`default_nettype none
// ============================================================================
// Module      : jt8255_peer
// Description : Peripheral-side agent for the 8255 strobed handshake.
//               RX: answers OBF# with an ACK# pulse and queues the port byte
//               in a small FIFO. TX: drives a byte, pulses STB#, then follows
//               the IBF set/clear cycle before accepting the next byte.
// Revision    : 1.0 - initial release
// ============================================================================
module jt8255_peer #(
    parameter int DEPTH = 4,    // RX FIFO entries, power of two 2..16
    parameter int PULSE = 4,    // ACK#/STB# low width in clk cycles (>=1)
    parameter int SETUP = 2     // pdout stable cycles before STB# falls (>=0)
) (
    input  logic       rst,
    input  logic       clk,
    // 8255 output port (receive side)
    input  logic [7:0] pdin,
    input  logic       obfn,
    output logic       ackn,
    // RX stream
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    // TX stream
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    // 8255 input port (transmit side)
    output logic [7:0] pdout,
    output logic       stbn,
    input  logic       ibf,
    // status
    output logic       rx_busy,
    output logic       tx_busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = 16;
    localparam logic [AW:0]   c_DEPTH      = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] c_PULSE_LAST = CW'(PULSE - 1);
    localparam logic [CW-1:0] c_SETUP_LAST = CW'(SETUP - 1);

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ACK  = 2'd1,
        R_WAIT = 2'd2
    } rx_state_t;

    typedef enum logic [2:0] {
        T_IDLE  = 3'd0,
        T_SETUP = 3'd1,
        T_STB   = 3'd2,
        T_FULL  = 3'd3,
        T_EMPTY = 3'd4
    } tx_state_t;

    // ------------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------------
    logic r_obf_m, r_obf_s;
    logic r_ibf_m, r_ibf_s;

    // Two-flop synchronisers; OBF# idles high, IBF idles low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_obf_m <= 1'b1;
            r_obf_s <= 1'b1;
            r_ibf_m <= 1'b0;
            r_ibf_s <= 1'b0;
        end else begin
            r_obf_m <= obfn;
            r_obf_s <= r_obf_m;
            r_ibf_m <= ibf;
            r_ibf_s <= r_ibf_m;
        end
    end

    // ------------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------------
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push, w_pop;

    assign w_pop    = rx_valid && rx_ready;
    assign rx_valid = (r_count != '0);
    assign rx_data  = r_mem[r_rd_ptr];

    // FIFO storage, pointers and occupancy; simultaneous push/pop keeps count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= pdin;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // RX FSM
    // ------------------------------------------------------------------------
    rx_state_t     r_rx_state, w_rx_next;
    logic [CW-1:0] r_rx_cnt, w_rx_cnt_next;

    // RX state and pulse counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_state <= R_IDLE;
            r_rx_cnt   <= '0;
        end else begin
            r_rx_state <= w_rx_next;
            r_rx_cnt   <= w_rx_cnt_next;
        end
    end

    // RX next state: room is checked only on entry, so the final push never
    // overflows (pops during the pulse can only free space)
    always_comb begin
        w_rx_next     = r_rx_state;
        w_rx_cnt_next = r_rx_cnt;
        w_push        = 1'b0;
        case (r_rx_state)
            R_IDLE: begin
                if (!r_obf_s && (r_count < c_DEPTH)) begin
                    w_rx_next     = R_ACK;
                    w_rx_cnt_next = '0;
                end
            end
            R_ACK: begin
                if (r_rx_cnt == c_PULSE_LAST) begin
                    w_push        = 1'b1;
                    w_rx_next     = R_WAIT;
                    w_rx_cnt_next = '0;
                end else begin
                    w_rx_cnt_next = r_rx_cnt + 1'b1;
                end
            end
            R_WAIT: begin
                // wait for OBF# to deassert so one byte is acknowledged once
                if (r_obf_s) w_rx_next = R_IDLE;
            end
            default: w_rx_next = R_IDLE;
        endcase
    end

    // ACK# is decoded straight from the state register so reset releases it
    // asynchronously
    assign ackn    = (r_rx_state != R_ACK);
    assign rx_busy = (r_rx_state != R_IDLE);

    // ------------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------------
    tx_state_t     r_tx_state, w_tx_next;
    logic [CW-1:0] r_tx_cnt, w_tx_cnt_next;
    logic          r_tx_ready;
    logic [7:0]    r_pdout;
    logic          w_accept;

    assign w_accept = tx_valid && r_tx_ready;

    // TX state, counter, registered ready and output data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_state <= T_IDLE;
            r_tx_cnt   <= '0;
            r_tx_ready <= 1'b0;
            r_pdout    <= 8'hff;
        end else begin
            r_tx_state <= w_tx_next;
            r_tx_cnt   <= w_tx_cnt_next;
            // r_ibf_m is the value r_ibf_s takes at this edge, so ready is
            // exactly "idle and synchronised IBF low" in the next cycle
            r_tx_ready <= (w_tx_next == T_IDLE) && !r_ibf_m;
            if (w_accept) r_pdout <= tx_data;
        end
    end

    // TX next state: setup, strobe, then the IBF set/clear cycle
    always_comb begin
        w_tx_next     = r_tx_state;
        w_tx_cnt_next = r_tx_cnt;
        case (r_tx_state)
            T_IDLE: begin
                if (w_accept) begin
                    w_tx_cnt_next = '0;
                    w_tx_next     = (SETUP == 0) ? T_STB : T_SETUP;
                end
            end
            T_SETUP: begin
                if (r_tx_cnt == c_SETUP_LAST) begin
                    w_tx_next     = T_STB;
                    w_tx_cnt_next = '0;
                end else begin
                    w_tx_cnt_next = r_tx_cnt + 1'b1;
                end
            end
            T_STB: begin
                if (r_tx_cnt == c_PULSE_LAST) begin
                    w_tx_next     = T_FULL;
                    w_tx_cnt_next = '0;
                end else begin
                    w_tx_cnt_next = r_tx_cnt + 1'b1;
                end
            end
            T_FULL: begin
                // the 8255 has latched the byte once IBF rises
                if (r_ibf_s) w_tx_next = T_EMPTY;
            end
            T_EMPTY: begin
                // the CPU has read the port once IBF falls
                if (!r_ibf_s) w_tx_next = T_IDLE;
            end
            default: w_tx_next = T_IDLE;
        endcase
    end

    // STB# decoded from the state register; pdout holds until next accept.
    // In mode 2 the enclosing level muxes pdin/pdout on the shared port
    // using ackn.
    assign stbn     = (r_tx_state != T_STB);
    assign tx_busy  = (r_tx_state != T_IDLE);
    assign tx_ready = r_tx_ready;
    assign pdout    = r_pdout;

endmodule
`default_nettype wire

// File: tb/tb_jt8255_peer.sv
`default_nettype none
// ============================================================================
// Module      : tb_jt8255_peer
// Description : Self-checking bench for jt8255_peer with RX/TX scoreboards
//               and a small behavioural 8255 model in the stimulus tasks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jt8255_peer;

    logic       rst, clk;
    logic [7:0] pdin;
    logic       obfn, ackn;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic [7:0] pdout;
    logic       stbn, ibf;
    logic       rx_busy, tx_busy;

    int checks   = 0;
    int failures = 0;

    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];

    jt8255_peer #(.DEPTH(4), .PULSE(4), .SETUP(2)) dut (
        .rst      (rst),
        .clk      (clk),
        .pdin     (pdin),
        .obfn     (obfn),
        .ackn     (ackn),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .pdout    (pdout),
        .stbn     (stbn),
        .ibf      (ibf),
        .rx_busy  (rx_busy),
        .tx_busy  (tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance to just after the next rising edge
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // 8255 model: CPU writes a byte, OBF# falls, OBF# rises on ACK# falling
    task automatic cpu_write(input logic [7:0] b);
        int n;
        pdin = b;
        obfn = 1'b0;
        rx_q.push_back(b);
        n = 0;
        while (ackn !== 1'b0 && n < 40) begin tick; n++; end
        checks++;
        if (ackn !== 1'b0) begin
            failures++;
            $display("FAIL ack_start byte=%h ackn=%b required 0", b, ackn);
        end
        obfn = 1'b1;
        n = 0;
        while (ackn !== 1'b1 && n < 40) begin tick; n++; end
        checks++;
        if (ackn !== 1'b1) begin
            failures++;
            $display("FAIL ack_end byte=%h ackn=%b required 1", b, ackn);
        end
    endtask

    // consumer pop: compare FIFO head against the scoreboard
    task automatic rx_pop_check(input string name);
        int n;
        logic [7:0] expv;
        rx_ready = 1'b1;
        n = 0;
        while (rx_valid !== 1'b1 && n < 40) begin tick; n++; end
        checks++;
        if (rx_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s rx_valid=%b required 1", name, rx_valid);
        end else if (rx_q.size() == 0) begin
            failures++;
            $display("FAIL %s unexpected byte rx_data=%h required none", name, rx_data);
        end else begin
            expv = rx_q.pop_front();
            if (rx_data !== expv) begin
                failures++;
                $display("FAIL %s rx_data=%h required %h", name, rx_data, expv);
            end
        end
        tick;
        rx_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; obfn = 1'b1; ibf = 1'b0; pdin = 8'h00;
        rx_ready = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        repeat (3) tick;
        rst = 1'b0;
        checks++;
        if ({ackn, stbn, pdout, rx_valid, rx_data, tx_ready, rx_busy, tx_busy}
            !== {1'b1, 1'b1, 8'hff, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_values ackn=%b stbn=%b pdout=%h rx_valid=%b rx_data=%h tx_ready=%b busy=%b%b required 1 1 ff 0 00 0 00",
                     ackn, stbn, pdout, rx_valid, rx_data, tx_ready, rx_busy, tx_busy);
        end
        tick;
        checks++;
        if (tx_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_tx_ready tx_ready=%b required 1", tx_ready);
        end
    endtask

    task automatic test_single_rx;
        logic ok;
        pdin = 8'h5a;
        obfn = 1'b0;
        rx_q.push_back(8'h5a);
        for (int k = 1; k <= 7; k++) begin
            tick;
            checks++;
            if (ackn !== ((k >= 3 && k <= 6) ? 1'b0 : 1'b1)) begin
                failures++;
                $display("FAIL ack_timing cycle=%0d ackn=%b required %b",
                         k, ackn, (k >= 3 && k <= 6) ? 1'b0 : 1'b1);
            end
            if (k == 3) obfn = 1'b1;
            if (k == 6 || k == 7) begin
                checks++;
                if (rx_valid !== (k == 7)) begin
                    failures++;
                    $display("FAIL rx_valid_latency cycle=%0d rx_valid=%b required %b",
                             k, rx_valid, (k == 7));
                end
            end
        end
        ok = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick;
            if (ackn !== 1'b1) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL no_double_ack saw ackn=0 required 1");
        end
        rx_pop_check("single_rx");
        checks++;
        if (rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_rx_empty rx_valid=%b required 0", rx_valid);
        end
    endtask

    task automatic test_fifo_full;
        logic ok;
        int n;
        rx_ready = 1'b0;
        cpu_write(8'h11);
        cpu_write(8'h22);
        cpu_write(8'h33);
        cpu_write(8'h44);
        pdin = 8'h55;
        obfn = 1'b0;
        rx_q.push_back(8'h55);
        ok = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick;
            if (ackn !== 1'b1) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL full_holdoff saw ackn=0 required 1");
        end
        rx_pop_check("full_pop0");
        n = 0;
        while (ackn !== 1'b0 && n < 20) begin tick; n++; end
        checks++;
        if (ackn !== 1'b0) begin
            failures++;
            $display("FAIL fifth_ack ackn=%b required 0", ackn);
        end
        obfn = 1'b1;
        n = 0;
        while (ackn !== 1'b1 && n < 20) begin tick; n++; end
        rx_pop_check("full_pop1");
        rx_pop_check("full_pop2");
        rx_pop_check("full_pop3");
        rx_pop_check("full_pop4");
        checks++;
        if (rx_valid !== 1'b0 || rx_q.size() != 0) begin
            failures++;
            $display("FAIL full_drain rx_valid=%b left=%0d required 0 0", rx_valid, rx_q.size());
        end
    endtask

    task automatic test_tx;
        int n;
        logic exp_stbn, exp_rdy;
        logic [7:0] expv;
        n = 0;
        while (tx_ready !== 1'b1 && n < 20) begin tick; n++; end
        tx_data  = 8'ha7;
        tx_valid = 1'b1;
        tx_q.push_back(8'ha7);
        tick;
        tx_valid = 1'b0;
        checks++;
        if (pdout !== 8'ha7 || stbn !== 1'b1 || tx_ready !== 1'b0) begin
            failures++;
            $display("FAIL tx_accept pdout=%h stbn=%b tx_ready=%b required a7 1 0",
                     pdout, stbn, tx_ready);
        end
        for (int k = 1; k <= 18; k++) begin
            tick;
            exp_stbn = (k >= 2 && k <= 5) ? 1'b0 : 1'b1;
            exp_rdy  = (k >= 18);
            checks++;
            if (stbn !== exp_stbn || tx_ready !== exp_rdy || tx_busy !== !exp_rdy) begin
                failures++;
                $display("FAIL tx_timing cycle=%0d stbn=%b tx_ready=%b tx_busy=%b required %b %b %b",
                         k, stbn, tx_ready, tx_busy, exp_stbn, exp_rdy, !exp_rdy);
            end
            if (k == 2) begin
                checks++;
                if (tx_q.size() == 0) begin
                    failures++;
                    $display("FAIL tx_strobe unexpected pdout=%h required none", pdout);
                end else begin
                    expv = tx_q.pop_front();
                    if (pdout !== expv) begin
                        failures++;
                        $display("FAIL tx_strobe pdout=%h required %h", pdout, expv);
                    end
                end
            end
            if (k == 5)  ibf = 1'b1;
            if (k == 15) ibf = 1'b0;
        end
        checks++;
        if (pdout !== 8'ha7) begin
            failures++;
            $display("FAIL tx_hold pdout=%h required a7", pdout);
        end
    endtask

    task automatic test_reset_mid_pulse;
        int n;
        logic ok;
        // leave one byte queued so the clear is visible
        cpu_write(8'h77);
        pdin = 8'h99;
        obfn = 1'b0;
        n = 0;
        while (ackn !== 1'b0 && n < 20) begin tick; n++; end
        tick;
        #1 rst = 1'b1;
        #1;
        checks++;
        if (ackn !== 1'b1 || rx_busy !== 1'b0 || rx_valid !== 1'b0 || rx_data !== 8'h00) begin
            failures++;
            $display("FAIL rst_mid_ack ackn=%b rx_busy=%b rx_valid=%b rx_data=%h required 1 0 0 00",
                     ackn, rx_busy, rx_valid, rx_data);
        end
        rx_q.delete();
        obfn = 1'b1;
        tick;
        rst = 1'b0;
        ok = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick;
            if (rx_valid !== 1'b0 || ackn !== 1'b1) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL rst_no_capture saw rx_valid=1 or ackn=0 required 0 1");
        end
        n = 0;
        while (tx_ready !== 1'b1 && n < 20) begin tick; n++; end
        tx_data  = 8'h3c;
        tx_valid = 1'b1;
        tick;
        tx_valid = 1'b0;
        n = 0;
        while (stbn !== 1'b0 && n < 20) begin tick; n++; end
        tick;
        #1 rst = 1'b1;
        #1;
        checks++;
        if (stbn !== 1'b1 || tx_busy !== 1'b0 || pdout !== 8'hff || tx_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_stb stbn=%b tx_busy=%b pdout=%h tx_ready=%b required 1 0 ff 0",
                     stbn, tx_busy, pdout, tx_ready);
        end
        tick;
        rst = 1'b0;
        tick;
        checks++;
        if (tx_ready !== 1'b1 || rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_release tx_ready=%b rx_valid=%b required 1 0", tx_ready, rx_valid);
        end
    endtask

    initial begin
        test_reset;
        test_single_rx;
        test_fifo_full;
        test_tx;
        test_reset_mid_pulse;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
